sid_bus_master: RTL and testbench

- Bus initiator for the SID register interface (cs/we/addr/data_in/data_out).
- Replays a queued stream of SID register writes, reads and timed delays, e.g. from a tune player or loader.
- Issues at most one bus access per ce_1m tick. The access is a single-clk cs pulse, which the SID register decoder latches on that posedge.
- Read results return on a valid strobe; supports one or two SID chips.

---
 rtl/sid_bus_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_sid_bus_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_bus_master.sv
// SID register-bus initiator: replays queued writes/reads/delays, one access per ce_1m tick.
// Latency: cs one clk after the popping tick, rd_valid two clk after cs; cmd_ready drops while the FIFO is full.
module sid_bus_master #(
  parameter int DUAL       = 1,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ce_1m,
  input  logic                              flush,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [15:0]                       cmd_data,
  output logic [DEPTH_LOG2:0]               level,
  output logic                              busy,
  output logic [((DUAL != 0) ? 2 : 1)-1:0]  bus_cs,
  output logic                              bus_we,
  output logic [4:0]                        bus_addr,
  output logic [7:0]                        bus_data_in,
  input  logic [7:0]                        bus_data_out,
  output logic                              rd_valid,
  output logic [7:0]                        rd_data,
  output logic [5:0]                        rd_addr
);

  localparam int N = (DUAL != 0) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, BUS, RCAP, DELAY} state_t;

  state_t         state_q, state_d;
  logic [12:0]    cnt_q, cnt_d;
  logic [N-1:0]   cs_q, cs_d;
  logic           we_q, we_d;
  logic [4:0]     addr_q, addr_d;
  logic [7:0]     din_q, din_d;
  logic           sel_q, sel_d;
  logic           is_rd_q, is_rd_d;
  logic           rd_valid_q, rd_valid_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic [5:0]     rd_addr_q, rd_addr_d;

  logic [15:0]    head;
  logic           fifo_full;
  logic           fifo_pop;
  logic [1:0]     head_type;
  logic [1:0]     cs_one;

  sid_fifo #(
    .W          (16),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (cmd_valid && cmd_ready),
    .wr_dat  (cmd_data),
    .pop     (fifo_pop),
    .rd_dat  (head),
    .level   (level),
    .full    (fifo_full)
  );

  assign head_type = head[15:14];
  // Single-chip builds ignore the select bit and always drive cs[0].
  assign cs_one    = ((DUAL != 0) && head[13]) ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_d       = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    sel_d      = sel_q;
    is_rd_d    = is_rd_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ce_1m && (level != '0) && !flush) begin
          fifo_pop = 1'b1;
          case (head_type)
            2'b00, 2'b01: begin
              cs_d    = cs_one[N-1:0];
              we_d    = (head_type == 2'b00);
              addr_d  = head[12:8];
              din_d   = (head_type == 2'b00) ? head[7:0] : 8'h00;
              sel_d   = head[13];
              is_rd_d = (head_type == 2'b01);
              state_d = BUS;
            end
            2'b10: begin
              if (head[12:0] != 13'd0) begin
                cnt_d   = head[12:0];
                state_d = DELAY;
              end
            end
            default: ;
          endcase
        end
      end

      BUS: begin
        state_d = is_rd_q ? RCAP : IDLE;
      end

      // The decoder latched the read on the cs edge; its data is stable now.
      RCAP: begin
        rd_valid_d = 1'b1;
        rd_data_d  = bus_data_out;
        rd_addr_d  = {sel_q, addr_q};
        state_d    = IDLE;
      end

      DELAY: begin
        if (flush) begin
          cnt_d   = 13'd0;
          state_d = IDLE;
        end else if (ce_1m) begin
          cnt_d = cnt_q - 13'd1;
          if (cnt_q == 13'd1) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cs_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      sel_q      <= 1'b0;
      is_rd_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      sel_q      <= sel_d;
      is_rd_q    <= is_rd_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != IDLE) || (level != '0);
  assign bus_cs      = cs_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_data_in = din_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_addr     = rd_addr_q;

endmodule

// Generic synchronous FIFO with registered occupancy and a flush that drops same-cycle pushes.
// Latency: a pushed entry is visible at the head the cycle after the push; push is ignored when full.
module sid_fifo #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          wr_dat,
  input  logic                  pop,
  output logic [W-1:0]          rd_dat,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [W-1:0]          mem_q [DEPTH];
  logic [W-1:0]          mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && (level_q != '0) && !flush;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wr_dat;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign rd_dat = mem_q[rptr_q];
  assign level  = level_q;

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master: bus accesses and read returns are matched against scoreboard queues.
module tb_sid_bus_master;

  typedef struct packed {
    logic [1:0] cs;
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
  } bus_t;

  typedef struct packed {
    logic [7:0] data;
    logic [5:0] addr;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_1m = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [4:0]  level;
  logic        busy;
  logic [1:0]  bus_cs;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [5:0]  rd_addr;

  int checks = 0;
  int errors = 0;
  bus_t bus_q[$];
  rd_t  rd_q[$];
  logic [1:0] cs_prev = '0;
  logic [1:0] cs_seen;

  sid_bus_master #(.DUAL(1), .DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce_1m        (ce_1m),
    .flush        (flush),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .level        (level),
    .busy         (busy),
    .bus_cs       (bus_cs),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_addr      (rd_addr)
  );

  always #5 clk = ~clk;

  // Chip model: a read strobe loads the chip's read value onto the data bus.
  always @(posedge clk) begin
    if (bus_cs[1] && !bus_we) bus_data_out <= 8'hA5;
    else if (bus_cs[0] && !bus_we) bus_data_out <= 8'h3C;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_cs != 2'b00) begin
        bus_t got;
        got = '{cs: bus_cs, we: bus_we, addr: bus_addr, din: bus_data_in};
        check("cs_spacing", {30'd0, cs_prev}, 32'd0);
        check("bus_expected", {31'd0, bus_q.size() != 0}, 32'd1);
        if (bus_q.size() != 0) check("bus_access", {16'd0, got}, {16'd0, bus_q.pop_front()});
      end
      if (rd_valid) begin
        check("rd_expected", {31'd0, rd_q.size() != 0}, 32'd1);
        if (rd_q.size() != 0) check("rd_result", {18'd0, rd_data, rd_addr}, {18'd0, rd_q.pop_front()});
      end
    end
    cs_prev <= reset_n ? bus_cs : 2'b00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One tick; returns cs as seen in the cycle after the tick, then leaves a 5-clk tick spacing.
  task automatic tick_obs(output logic [1:0] cs);
    @(negedge clk);
    ce_1m = 1'b1;
    @(negedge clk);
    ce_1m = 1'b0;
    cs = bus_cs;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", {30'd0, bus_cs}, 32'd0);
    check("rst_we_addr_din", {18'd0, bus_we, bus_addr, bus_data_in}, 32'd0);
    check("rst_rd", {17'd0, rd_valid, rd_data, rd_addr}, 32'd0);
    check("rst_ready_level_busy", {25'd0, cmd_ready, level, busy}, {25'd0, 1'b1, 5'd0, 1'b0});
    reset_n = 1'b1;
    @(negedge clk);

    // Write to chip 0
    push(16'h180F);
    check("wr_level_busy", {26'd0, level, busy}, {26'd0, 5'd1, 1'b1});
    bus_q.push_back('{cs: 2'b01, we: 1'b1, addr: 5'h18, din: 8'h0F});
    @(negedge clk);
    ce_1m = 1'b1;
    @(negedge clk);
    ce_1m = 1'b0;
    check("wr_cs", {16'd0, bus_cs, bus_we, bus_addr, bus_data_in}, {16'd0, 2'b01, 1'b1, 5'h18, 8'h0F});
    check("wr_level", {27'd0, level}, 32'd0);
    @(negedge clk);
    check("wr_cs_drop_hold", {16'd0, bus_cs, bus_we, bus_addr, bus_data_in}, {16'd0, 2'b00, 1'b0, 5'h18, 8'h0F});
    repeat (3) @(negedge clk);

    // Read from chip 1
    push(16'h7B00);
    bus_q.push_back('{cs: 2'b10, we: 1'b0, addr: 5'h1B, din: 8'h00});
    rd_q.push_back('{data: 8'hA5, addr: 6'h3B});
    @(negedge clk);
    ce_1m = 1'b1;
    @(negedge clk);
    ce_1m = 1'b0;
    check("rd_cs", {16'd0, bus_cs, bus_we, bus_addr, bus_data_in}, {16'd0, 2'b10, 1'b0, 5'h1B, 8'h00});
    @(negedge clk);
    check("rd_valid_t2", {31'd0, rd_valid}, 32'd0);
    @(negedge clk);
    check("rd_valid_t3", {17'd0, rd_valid, rd_data, rd_addr}, {17'd0, 1'b1, 8'hA5, 6'h3B});
    @(negedge clk);
    check("rd_valid_t4", {30'd0, rd_valid, busy}, 32'd0);
    repeat (2) @(negedge clk);

    // Delay C=3 then write: write issues on tick k+4
    push(16'h8003);
    push(16'h0411);
    bus_q.push_back('{cs: 2'b01, we: 1'b1, addr: 5'h04, din: 8'h11});
    for (int i = 0; i < 4; i++) begin
      tick_obs(cs_seen);
      check($sformatf("dly3_tick%0d", i), {30'd0, cs_seen}, 32'd0);
    end
    tick_obs(cs_seen);
    check("dly3_write", {30'd0, cs_seen}, 32'd1);

    // Delay C=0 and nop each consume exactly one tick
    push(16'h8000);
    push(16'h0422);
    bus_q.push_back('{cs: 2'b01, we: 1'b1, addr: 5'h04, din: 8'h22});
    tick_obs(cs_seen);
    check("dly0_tick", {30'd0, cs_seen}, 32'd0);
    tick_obs(cs_seen);
    check("dly0_write", {30'd0, cs_seen}, 32'd1);
    push(16'hC000);
    tick_obs(cs_seen);
    check("nop_tick", {25'd0, cs_seen, level}, 32'd0);

    // Fill the FIFO; the overflow push must be dropped
    for (int i = 0; i < 16; i++) begin
      push({3'b000, 5'(i), 8'(i + 8'h40)});
      bus_q.push_back('{cs: 2'b01, we: 1'b1, addr: 5'(i), din: 8'(i + 8'h40)});
    end
    check("full_level_ready", {26'd0, cmd_ready, level}, {26'd0, 1'b0, 5'd16});
    push(16'h1FEE);
    check("full_overflow", {27'd0, level}, 32'd16);
    @(negedge clk);
    ce_1m = 1'b1;
    @(negedge clk);
    ce_1m = 1'b0;
    check("full_after_tick", {26'd0, cmd_ready, level}, {26'd0, 1'b1, 5'd15});
    repeat (3) @(negedge clk);
    for (int i = 1; i < 16; i++) begin
      tick_obs(cs_seen);
      check($sformatf("drain%0d", i), {30'd0, cs_seen}, 32'd1);
    end
    tick_obs(cs_seen);
    check("drain_empty", {29'd0, cs_seen, busy}, 32'd0);

    // Flush during a long delay, with a same-cycle push discarded
    push(16'h8064);
    push(16'h0A01);
    push(16'h0A02);
    push(16'h0A03);
    tick_obs(cs_seen);
    check("fl_level", {27'd0, level}, 32'd3);
    tick_obs(cs_seen);
    @(negedge clk);
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 16'h0A04;
    @(negedge clk);
    flush     = 1'b0;
    cmd_valid = 1'b0;
    check("fl_level_busy", {26'd0, level, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick_obs(cs_seen);
      check($sformatf("fl_no_cs%0d", i), {30'd0, cs_seen}, 32'd0);
    end

    // Flush in the cs cycle of a read: the read still completes
    push(16'h5900);
    bus_q.push_back('{cs: 2'b01, we: 1'b0, addr: 5'h19, din: 8'h00});
    rd_q.push_back('{data: 8'h3C, addr: 6'h19});
    @(negedge clk);
    ce_1m = 1'b1;
    @(negedge clk);
    ce_1m = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check("flrd_valid", {17'd0, rd_valid, rd_data, rd_addr}, {17'd0, 1'b1, 8'h3C, 6'h19});
    repeat (3) @(negedge clk);

    // Reset asserted in the cs-high cycle
    push(16'h2577);
    push(16'h0102);
    bus_q.push_back('{cs: 2'b10, we: 1'b1, addr: 5'h05, din: 8'h77});
    @(negedge clk);
    ce_1m = 1'b1;
    @(negedge clk);
    ce_1m = 1'b0;
    check("rst_mid_cs_before", {30'd0, bus_cs}, 32'd2);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_cs", {30'd0, bus_cs}, 32'd0);
    check("rst_mid_outs", {17'd0, bus_we, bus_addr, bus_data_in, rd_valid}, 32'd0);
    check("rst_mid_ready_level", {26'd0, cmd_ready, level}, {26'd0, 1'b1, 5'd0});
    @(negedge clk);
    reset_n = 1'b1;
    tick_obs(cs_seen);
    check("rst_cmd_lost", {30'd0, cs_seen}, 32'd0);

    check("bus_q_empty", bus_q.size(), 32'd0);
    check("rd_q_empty", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
